// File: rtl/st_frm_arb.sv
// Frame-granular round-robin arbiter feeding one Avalon-ST decoder input.
// Optional idle-beat watchdog: define ARB_TIMEOUT_EN.
module st_frm_arb #(
  parameter int N_CH    = 4,
  parameter int ST      = 24,
  parameter int w_LEN   = 16,
  parameter int w_CH    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         ch_valid,
  input  logic [N_CH-1:0]         ch_sop,
  input  logic [N_CH-1:0]         ch_eop,
  input  logic [N_CH*ST-1:0]      ch_data,
  input  logic [N_CH*w_LEN-1:0]   ch_len,
  output logic [N_CH-1:0]         ch_ready,
  input  logic                    dec_ready,
  output logic                    dec_valid,
  output logic                    dec_sop,
  output logic                    dec_eop,
  output logic [ST-1:0]           dec_data,
  output logic [w_LEN-1:0]        dec_len,
  output logic [w_CH-1:0]         dec_ch,
  output logic                    err_len,
  output logic                    err_nosop,
  output logic                    frm_done
);

  typedef enum logic {IDLE, XFER} st_t;

  st_t st, st_nx;

  logic [w_CH-1:0]  ptr;
  logic [w_CH-1:0]  grant;
  logic [w_LEN-1:0] cnt;
  logic [w_LEN-1:0] cnt_nx;
  logic [w_LEN-1:0] len_ref;

  logic [ST-1:0]    data_a [N_CH];
  logic [w_LEN-1:0] len_a  [N_CH];

  logic [N_CH-1:0] cand;
  logic [N_CH-1:0] orph;
  logic [w_CH-1:0] sel;
  logic [w_CH-1:0] fl_idx;
  logic            sel_ok;
  logic            fl_ok;

  logic out_ok;
  logic g_valid;
  logic g_sop;
  logic g_eop;
  logic acc;
  logic len_bad;
  logic to_fire;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      data_a[i] = ch_data[i*ST +: ST];
      len_a[i]  = ch_len[i*w_LEN +: w_LEN];
    end
  end

  assign out_ok  = !dec_valid || dec_ready;
  assign g_valid = ch_valid[grant];
  assign g_sop   = ch_sop[grant];
  assign g_eop   = ch_eop[grant];
  assign acc     = (st == XFER) && out_ok && g_valid;

  // Round-robin search starts just past the last served channel.
  always_comb begin
    int j;
    j      = 0;
    cand   = ch_valid & ch_sop;
    orph   = ch_valid & ~ch_sop;
    sel    = '0;
    sel_ok = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      j = (int'(ptr) + k) % N_CH;
      if (!sel_ok && cand[j]) begin
        sel_ok = 1'b1;
        sel    = w_CH'(j);
      end
    end
    fl_ok  = 1'b0;
    fl_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (orph[i]) begin
        fl_ok  = 1'b1;
        fl_idx = w_CH'(i);
      end
    end
  end

  always_comb begin
    cnt_nx  = g_sop ? w_LEN'(1)
            : (&cnt ? cnt : cnt + 1'b1);
    len_ref = g_sop ? len_a[grant] : dec_len;
    len_bad = (cnt_nx != len_ref);
  end

`ifdef ARB_TIMEOUT_EN
  logic [w_LEN-1:0] wd;
  logic             wd_idle;

  assign wd_idle = (st == XFER) && out_ok && !g_valid;
  assign to_fire = wd_idle && (wd == w_LEN'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || st != XFER || acc || to_fire) begin
      wd <= '0;
    end else if (wd_idle) begin
      wd <= wd + 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    ch_ready = '0;
    unique case (st)
      IDLE: if (fl_ok) ch_ready[fl_idx] = 1'b1;
      XFER: ch_ready[grant] = out_ok;
      default: ch_ready = '0;
    endcase
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (sel_ok) st_nx = XFER;
      XFER: if ((acc && g_eop) || to_fire) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      ptr       <= w_CH'(N_CH - 1);
      grant     <= '0;
      cnt       <= '0;
      dec_valid <= 1'b0;
      dec_sop   <= 1'b0;
      dec_eop   <= 1'b0;
      dec_data  <= '0;
      dec_len   <= '0;
      dec_ch    <= '0;
      err_len   <= 1'b0;
      err_nosop <= 1'b0;
    end else begin
      st        <= st_nx;
      err_len   <= 1'b0;
      err_nosop <= (st == IDLE) && fl_ok;
      if (st == IDLE && sel_ok) grant <= sel;
      if (acc) begin
        cnt <= cnt_nx;
        if (g_eop) begin
          err_len <= len_bad;
          ptr     <= grant;
        end
      end
      if (to_fire) begin
        err_len <= 1'b1;
        ptr     <= grant;
      end
      if (out_ok) begin
        dec_valid <= acc || to_fire;
        if (acc) begin
          dec_sop  <= g_sop;
          dec_eop  <= g_eop;
          dec_data <= data_a[grant];
          dec_ch   <= grant;
          if (g_sop) dec_len <= len_a[grant];
        end else if (to_fire) begin
          dec_sop  <= 1'b0;
          dec_eop  <= 1'b1;
          dec_data <= '0;
          dec_ch   <= grant;
        end
      end
    end
  end

  assign frm_done = dec_valid && dec_eop && dec_ready;

endmodule

// File: doc/st_frm_arb.md
Name: st_frm_arb

Overview:
- Frame-granular round-robin arbiter that shares one turbo decoder Avalon-ST input among N_CH bus2st channels.
- Sits between the bus2st instances and the TurboDecoder.
- Locks the grant from a channel's sop beat to its eop beat and registers the output stream.
- Checks each frame's beat count against the channel-supplied st_len.
- Flushes malformed head-of-line beats so that no channel can deadlock the decoder.

Parameters:
N_CH, 4, number of requesting channels (2..16)
ST, 24, st data width in bits
w_LEN, 16, width of frame length (beats)
w_CH, 2, width of channel id; must satisfy 2**w_CH >= N_CH
TIMEOUT, 1024, idle-beat watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
ch_valid  in  N_CH  per-channel beat valid
ch_sop  in  N_CH  per-channel start of frame
ch_eop  in  N_CH  per-channel end of frame
ch_data  in  N_CH*ST  packed beat data; channel i occupies [i*ST +: ST]
ch_len  in  N_CH*w_LEN  packed frame length in beats; sampled on the sop beat
ch_ready  out  N_CH  per-channel beat accept
dec_ready  in  1  decoder accepts a beat
dec_valid  out  1  beat valid
dec_sop  out  1  start of frame
dec_eop  out  1  end of frame
dec_data  out  ST  beat data
dec_len  out  w_LEN  frame length; valid whenever dec_valid
dec_ch  out  w_CH  source channel of the current beat
err_len  out  1  one-cycle pulse: eop arrived with beat count != len
err_nosop  out  1  one-cycle pulse: a non-sop head beat was flushed
frm_done  out  1  one-cycle pulse per eop beat accepted by the decoder

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer ptr=N_CH-1, grant=0, beat counter=0.
- out_ok = !dec_valid | dec_ready.
- The output register loads only when out_ok. It holds its value while dec_valid && !dec_ready.
- A channel beat is accepted on a cycle where ch_valid[i] && ch_ready[i].
- Latency from acceptance to dec_valid is 1 cycle.
- ch_ready is combinational from state, grant and out_ok.
- FSM IDLE:
  - Candidates are channels with ch_valid && ch_sop.
  - Choose the first candidate searching ptr+1, ptr+2, ... modulo N_CH. Latch grant and go to XFER.
  - No ch_ready is asserted in the cycle of selection.
  - Flush rule: any channel with ch_valid && !ch_sop gets ch_ready=1 for that cycle. Its beat is discarded and err_nosop pulses. If several channels qualify, the lowest index is flushed.
  - Selection and flush may happen in the same cycle on different channels.
- FSM XFER:
  - ch_ready[grant] = out_ok; all other ch_ready are 0.
  - Each accepted beat is copied to the output register with dec_ch=grant.
  - dec_sop/dec_eop mirror the accepted beat.
  - On the sop beat: dec_len <= ch_len[grant], beat counter <= 1.
  - On each later beat the beat counter increments, saturating at all-ones.
  - On an accepted eop beat: if counter+1 (or 1 on a sop+eop single beat) != latched len, err_len pulses in the next cycle. Then ptr <= grant and the FSM returns to IDLE.
  - A second sop inside XFER is passed through unchanged, and the counter restarts from 1.
  - The frame is terminated only by eop; reaching len without eop does not end the frame.
- frm_done pulses in the cycle dec_valid && dec_eop && dec_ready.
- Mid-frame reset: grant is dropped and the output is cleared. Upstream remainder beats arrive without sop and are flushed by the IDLE rule.
- Length comparison is unsigned at w_LEN bits. len=0 with a single-beat frame flags err_len.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A w_LEN-wide watchdog counts XFER cycles where out_ok && !ch_valid[grant]. It clears on any accepted beat.
  - On reaching TIMEOUT, the arbiter emits one beat: dec_data=0, dec_eop=1, dec_sop=0, dec_ch=grant.
  - err_len pulses, ptr <= grant, and the FSM goes to IDLE. The channel's late beats are then flushed as no-sop.
- ARB_TIMEOUT_EN undefined: no watchdog logic; XFER waits indefinitely for eop.

Test Plan:
1. Round-robin fairness:
   - Stimulus: ch0 and ch2 each present 3-beat frames with len=3 repeatedly; dec_ready=1.
   - Expected: dec_ch sequence 0,0,0,2,2,2,0,...; each frame's beats contiguous; no err pulses; frm_done once per frame.
2. Backpressure:
   - Stimulus: a 4-beat frame on ch1; dec_ready toggles 1,0,0,1,...
   - Expected: dec_data stable while stalled; ch_ready[1] low while dec_valid && !dec_ready; all 4 beats delivered in order.
3. Length error:
   - Stimulus: ch3 sop with len=5, eop on the 4th beat.
   - Expected: err_len pulses exactly once, 1 cycle after the eop acceptance; FSM returns to IDLE.
4. Head-of-line flush:
   - Stimulus: in IDLE, ch2 presents valid with sop=0 while ch1 presents a sop.
   - Expected: ch2 beat consumed with err_nosop=1; ch1 granted; ch2 never appears on dec_ch.
5. Mid-frame reset:
   - Stimulus: rst asserted for 1 cycle during beat 2 of an 8-beat frame.
   - Expected: next cycle all outputs are 0; the remaining 6 beats are flushed with err_nosop pulses; the next sop frame is delivered normally.
6. Timeout (ARB_TIMEOUT_EN, TIMEOUT=16):
   - Stimulus: ch0 sends sop then stalls for 16 cycles.
   - Expected: a zero-data dec_eop beat on dec_ch=0; err_len pulses; grant released.
